// File: rtl/run_controller.sv
// Run controller: holds the processor in reset, runs it until a halt edge, then a tail window.
// Optional run timeout enabled by defining RUN_CONTROLLER_TIMEOUT_EN.
module run_controller #(
  parameter int unsigned RESET_CYCLES   = 10,
  parameter int unsigned TAIL_CYCLES    = 5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        HALT,
  output logic        CPU_RST_bar,
  output logic        RUNNING,
  output logic        DONE,
  output logic        TIMED_OUT,
  output logic [31:0] CYCLES,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_TAIL    = 3'd3,
    S_DONE    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] TAIL_LAST = 8'(TAIL_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  hold_cnt, hold_nx, tail_cnt, tail_nx;
  logic [31:0] cyc_nx;
  logic        halt_q, halt_edge;

  assign halt_edge = HALT & ~halt_q;
  assign STATE     = state;

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    tail_nx  = tail_cnt;
    cyc_nx   = CYCLES;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (START) begin
          state_nx = S_HOLD;
          hold_nx  = 8'd0;
          cyc_nx   = 32'd0;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = S_RUN;
        else                       hold_nx  = hold_cnt + 8'd1;
      end
      S_RUN: begin
        if (halt_edge) begin
          // Halt edge wins over a coincident timeout; CYCLES is not bumped.
          if (TAIL_CYCLES == 0) state_nx = S_DONE;
          else begin
            state_nx = S_TAIL;
            tail_nx  = 8'd0;
          end
        end else if (CYCLES != 32'hFFFF_FFFF) begin
          cyc_nx = CYCLES + 32'd1;
`ifdef RUN_CONTROLLER_TIMEOUT_EN
          if (cyc_nx == TIMEOUT_CYCLES) state_nx = S_TIMEOUT;
`endif
        end
      end
      S_TAIL: begin
        if (tail_cnt == TAIL_LAST) state_nx = S_DONE;
        else                       tail_nx  = tail_cnt + 8'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with STATE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      hold_cnt    <= 8'd0;
      tail_cnt    <= 8'd0;
      CYCLES      <= 32'd0;
      halt_q      <= 1'b0;
      CPU_RST_bar <= 1'b0;
      RUNNING     <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      tail_cnt    <= tail_nx;
      CYCLES      <= cyc_nx;
      halt_q      <= (state == S_IDLE || state == S_HOLD) ? 1'b0 : HALT;
      CPU_RST_bar <= (state_nx == S_RUN) || (state_nx == S_TAIL) || (state_nx == S_DONE);
      RUNNING     <= (state_nx == S_RUN) || (state_nx == S_TAIL);
      DONE        <= (state_nx == S_DONE);
    end
  end

`ifdef RUN_CONTROLLER_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) TIMED_OUT <= 1'b0;
    else     TIMED_OUT <= (state_nx == S_TIMEOUT);
  end
`else
  assign TIMED_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: expected outputs queued per driven cycle, popped after the edge.
module tb_run_controller;
  localparam int unsigned RC = 10;
  localparam int unsigned TC = 5;
  localparam logic [31:0] TO = 32'd20;

  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, HALT = 1'b0;
  logic        CPU_RST_bar, RUNNING, DONE, TIMED_OUT;
  logic [31:0] CYCLES;
  logic [2:0]  STATE;

  run_controller #(.RESET_CYCLES(RC), .TAIL_CYCLES(TC), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT(HALT),
    .CPU_RST_bar(CPU_RST_bar), .RUNNING(RUNNING), .DONE(DONE),
    .TIMED_OUT(TIMED_OUT), .CYCLES(CYCLES), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        rb;
    logic [31:0] cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic h, input logic r);
    START = s; HALT = h; RST = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic step_exp(input logic s, input logic h, input logic r, input string tag,
                          input logic [2:0] st, input logic rb, input logic [31:0] cyc);
    exp_t e;
    e.tag = tag; e.st = st; e.rb = rb; e.cyc = cyc;
    sbq.push_back(e);
    step(s, h, r);
    if (sbq.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".state"},   32'(STATE),       32'(e.st));
      chk({e.tag, ".rst_bar"}, 32'(CPU_RST_bar), 32'(e.rb));
      chk({e.tag, ".running"}, 32'(RUNNING),     32'(e.st == 3'd2 || e.st == 3'd3));
      chk({e.tag, ".done"},    32'(DONE),        32'(e.st == 3'd4));
      chk({e.tag, ".timeout"}, 32'(TIMED_OUT),   32'(e.st == 3'd5));
      chk({e.tag, ".cycles"},  CYCLES,           e.cyc);
    end
  endtask

  // START edge, RC-1 hold edges, then the edge that enters RUN.
  task automatic launch(input logic h);
    step_exp(1'b1, h, 1'b0, "start", 3'd1, 1'b0, 32'd0);
    for (int k = 1; k < int'(RC); k++) step_exp(1'b0, h, 1'b0, "hold", 3'd1, 1'b0, 32'd0);
    step_exp(1'b0, h, 1'b0, "run_entry", 3'd2, 1'b1, 32'd0);
  endtask

  initial begin
    step_exp(1'b0, 1'b0, 1'b1, "reset", 3'd0, 1'b0, 32'd0);
    step_exp(1'b1, 1'b1, 1'b1, "reset_prio", 3'd0, 1'b0, 32'd0);
    step_exp(1'b0, 1'b0, 1'b0, "idle", 3'd0, 1'b0, 32'd0);

    // Normal run: halt first sampled on the 8th RUN edge, START ignored in RUN/TAIL.
    launch(1'b0);
    for (int k = 1; k <= 7; k++) step_exp(k == 3, 1'b0, 1'b0, "run", 3'd2, 1'b1, 32'(k));
    step_exp(1'b0, 1'b1, 1'b0, "halt", 3'd3, 1'b1, 32'd7);
    for (int k = 1; k < int'(TC); k++) step_exp(k == 2, k % 2 == 1, 1'b0, "tail", 3'd3, 1'b1, 32'd7);
    step_exp(1'b0, 1'b0, 1'b0, "done", 3'd4, 1'b1, 32'd7);
    step_exp(1'b0, 1'b1, 1'b0, "done_hold", 3'd4, 1'b1, 32'd7);

    // HALT high through the reset hold: halt edge on the first RUN edge.
    launch(1'b1);
    step_exp(1'b0, 1'b1, 1'b0, "halt_first", 3'd3, 1'b1, 32'd0);
    for (int k = 1; k < int'(TC); k++) step_exp(1'b0, 1'b1, 1'b0, "tail2", 3'd3, 1'b1, 32'd0);
    step_exp(1'b0, 1'b1, 1'b0, "done2", 3'd4, 1'b1, 32'd0);

    // RST in the middle of a run.
    launch(1'b0);
    step_exp(1'b0, 1'b0, 1'b0, "run3", 3'd2, 1'b1, 32'd1);
    step_exp(1'b1, 1'b0, 1'b0, "run3_start", 3'd2, 1'b1, 32'd2);
    step_exp(1'b1, 1'b1, 1'b1, "rst_run", 3'd0, 1'b0, 32'd0);
    step_exp(1'b0, 1'b0, 1'b0, "idle_after", 3'd0, 1'b0, 32'd0);

`ifdef RUN_CONTROLLER_TIMEOUT_EN
    launch(1'b0);
    for (int k = 1; k < int'(TO); k++) step_exp(1'b0, 1'b0, 1'b0, "run_to", 3'd2, 1'b1, 32'(k));
    step_exp(1'b0, 1'b0, 1'b0, "timeout", 3'd5, 1'b0, TO);
    step_exp(1'b0, 1'b1, 1'b0, "timeout_hold", 3'd5, 1'b0, TO);
    launch(1'b0);
    for (int k = 1; k < int'(TO); k++) step_exp(1'b0, 1'b0, 1'b0, "run_to2", 3'd2, 1'b1, 32'(k));
    step_exp(1'b0, 1'b1, 1'b0, "halt_vs_to", 3'd3, 1'b1, TO - 32'd1);
`else
    launch(1'b0);
    for (int k = 1; k < 3000; k++) step(1'b0, 1'b0, 1'b0);
    step_exp(1'b0, 1'b0, 1'b0, "long_run", 3'd2, 1'b1, 32'd3000);
    step_exp(1'b0, 1'b1, 1'b0, "long_halt", 3'd3, 1'b1, 32'd3000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
